// File: rtl/debug_loader.sv
// debug_loader: assembles MSB-first instructions from UART bytes into instruction memory,
// then drives the pipeline's valid in run or single-step mode. Optional macro: LOADER_CHECKSUM_EN.
module debug_loader #(
  parameter int                   NB_DATA            = 8,
  parameter int                   NB_INSTR           = 32,
  parameter int                   N_ADDR             = 32,
  parameter int                   LOG2_N_INSMEM_ADDR = 5,
  parameter logic [NB_INSTR-1:0]  HALT_WORD          = 32'hFFFFFFFF
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NB_DATA-1:0]            i_rx_data,
  input  logic                          i_rx_valid,
  input  logic                          i_pipe_halt,
  output logic                          o_imem_wr_en,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_imem_addr,
  output logic [NB_INSTR-1:0]           o_imem_data,
  output logic                          o_pipe_valid,
  output logic                          o_pipe_reset,
  output logic [2:0]                    o_state,
  output logic                          o_error
);

  localparam int NBYTES  = NB_INSTR / NB_DATA;
  localparam int NB_BCNT = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int NB_PART = NB_INSTR - NB_DATA;

  localparam logic [NB_DATA-1:0] CMD_L = NB_DATA'(8'h4C);
  localparam logic [NB_DATA-1:0] CMD_R = NB_DATA'(8'h52);
  localparam logic [NB_DATA-1:0] CMD_S = NB_DATA'(8'h53);
  localparam logic [NB_DATA-1:0] CMD_P = NB_DATA'(8'h50);

  localparam logic [LOG2_N_INSMEM_ADDR-1:0] LAST_ADDR = LOG2_N_INSMEM_ADDR'(N_ADDR - 1);
  localparam logic [NB_BCNT-1:0]            LAST_BYTE = NB_BCNT'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    RUN   = 3'd3,
    STEP  = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6,
    CHECK = 3'd7
  } state_t;

  state_t                          state_q, state_d;
  logic [NB_PART-1:0]              word_q, word_d;
  logic [NB_INSTR-1:0]             full_word;
  logic [NB_BCNT-1:0]              bcnt_q, bcnt_d;
  logic [LOG2_N_INSMEM_ADDR-1:0]   addr_q, addr_d;
  logic                            wr_en_q, wr_en_d;
  logic [LOG2_N_INSMEM_ADDR-1:0]   waddr_q, waddr_d;
  logic [NB_INSTR-1:0]             wdata_q, wdata_d;
  logic                            valid_q, valid_d;
  logic                            preset_q, preset_d;
  logic                            err_q, err_d;
  logic                            load_entry;
  logic                            is_l, is_r, is_s, is_p;

  assign is_l = i_rx_valid && (i_rx_data == CMD_L);
  assign is_r = i_rx_valid && (i_rx_data == CMD_R);
  assign is_s = i_rx_valid && (i_rx_data == CMD_S);
  assign is_p = i_rx_valid && (i_rx_data == CMD_P);

  assign full_word  = {word_q, i_rx_data};
  assign load_entry = (state_d == LOAD) && (state_q != LOAD);

`ifdef LOADER_CHECKSUM_EN
  logic [NB_DATA-1:0] xor_q, xor_d;
  localparam state_t POST_LOAD = CHECK;
`else
  localparam state_t POST_LOAD = READY;
`endif

  // State register plus all registered outputs
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      word_q   <= '0;
      bcnt_q   <= '0;
      addr_q   <= '0;
      wr_en_q  <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      valid_q  <= 1'b0;
      preset_q <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      bcnt_q   <= bcnt_d;
      addr_q   <= addr_d;
      wr_en_q  <= wr_en_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      valid_q  <= valid_d;
      preset_q <= preset_d;
      err_q    <= err_d;
    end
  end

  // Next state; halt outranks any byte arriving in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (is_l) state_d = LOAD;
      LOAD: begin
        // Decided on the write-strobe cycle so the move lands the cycle after the write
        if (wr_en_q) begin
          if (wdata_q == HALT_WORD)      state_d = POST_LOAD;
          else if (waddr_q == LAST_ADDR) state_d = ERROR;
        end
      end
      READY: begin
        if (is_r)      state_d = RUN;
        else if (is_s) state_d = STEP;
        else if (is_l) state_d = LOAD;
      end
      RUN: begin
        if (i_pipe_halt) state_d = DONE;
        else if (is_p)   state_d = READY;
      end
      STEP: begin
        if (i_pipe_halt) state_d = DONE;
        else if (is_r)   state_d = RUN;
        else if (is_p)   state_d = READY;
      end
      DONE:  if (is_l) state_d = LOAD;
      ERROR: if (is_l) state_d = LOAD;
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (i_rx_valid) state_d = (i_rx_data == xor_q) ? READY : ERROR;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    addr_d  = addr_q;
    wr_en_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (load_entry) begin
      word_d = '0;
      bcnt_d = '0;
      addr_d = '0;
    end else if (state_q == LOAD && i_rx_valid) begin
      word_d = full_word[NB_PART-1:0];
      if (bcnt_q == LAST_BYTE) begin
        bcnt_d  = '0;
        wr_en_d = 1'b1;
        waddr_d = addr_q;
        wdata_d = full_word;
        // Hold at the last slot; a non-halt write there ends in ERROR anyway
        if (addr_q != LAST_ADDR) addr_d = addr_q + LOG2_N_INSMEM_ADDR'(1);
      end else begin
        bcnt_d = bcnt_q + NB_BCNT'(1);
      end
    end
    valid_d  = (state_d == RUN) || ((state_d == STEP) && is_s);
    preset_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == ERROR) || (state_d == CHECK);
    err_d    = (state_d == ERROR);
  end

`ifdef LOADER_CHECKSUM_EN
  always_comb begin
    xor_d = xor_q;
    if (load_entry)                         xor_d = '0;
    else if (state_q == LOAD && i_rx_valid) xor_d = xor_q ^ i_rx_data;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) xor_q <= '0;
    else          xor_q <= xor_d;
  end
`endif

  assign o_imem_wr_en = wr_en_q;
  assign o_imem_addr  = waddr_q;
  assign o_imem_data  = wdata_q;
  assign o_pipe_valid = valid_q;
  assign o_pipe_reset = preset_q;
  assign o_state      = state_q;
  assign o_error      = err_q;

endmodule

// File: doc/debug_loader.md
Name: debug_loader

Overview:
Upstream control stage for the MIPS pipeline. It takes a byte stream from the UART receiver and assembles 32-bit instructions MSB-first. It writes those instructions into the pipeline's instruction memory, then drives the pipeline's i_valid in run or single-step mode until the pipeline reports halt. It also holds the pipeline in reset while a program is being loaded.

Parameters:
NB_DATA, 8, width of received bytes
NB_INSTR, 32, instruction word width
N_ADDR, 32, instruction memory depth in words
LOG2_N_INSMEM_ADDR, 5, instruction memory address width
HALT_WORD, 32'hFFFFFFFF, instruction word that terminates a load

Ports:
i_clock  in  1  single system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_rx_data  in  NB_DATA  received byte
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
i_pipe_halt  in  1  pipeline has retired HALT_WORD
o_imem_wr_en  out  1  instruction memory write strobe
o_imem_addr  out  LOG2_N_INSMEM_ADDR  instruction memory write address
o_imem_data  out  NB_INSTR  instruction memory write data
o_pipe_valid  out  1  drives the pipeline's i_valid
o_pipe_reset  out  1  active-high pipeline reset
o_state  out  3  current state encoding
o_error  out  1  sticky error flag

Behaviour:
- Reset (i_reset=0, asynchronous): state=IDLE; o_pipe_reset=1; all other outputs 0; address counter and byte counter cleared.
- Command bytes: 'L'=0x4C, 'R'=0x52, 'S'=0x53, 'P'=0x50. Bytes not listed for the current state are ignored.
- All outputs are registered.
- State encodings: IDLE=0, LOAD=1, READY=2, RUN=3, STEP=4, DONE=5, ERROR=6, CHECK=7 (CHECK only with the optional feature).
- IDLE: 'L' -> LOAD. Address and byte counters are cleared on entry.
- LOAD:
  - o_pipe_reset=1.
  - Each accepted byte shifts into the word register, MSB-first.
  - The 4th byte accepted on cycle N gives o_imem_wr_en=1 for exactly cycle N+1, with the current address and word. The address increments after the write; the byte counter returns to 0.
  - Written word == HALT_WORD -> READY (or CHECK), the cycle after the write.
  - Non-halt word written at address N_ADDR-1 -> ERROR. The address never wraps.
- READY: o_pipe_reset=0 from the first READY cycle. 'R' -> RUN. 'S' -> STEP. 'L' -> LOAD (reasserts o_pipe_reset and clears counters).
- RUN: o_pipe_valid=1 every cycle. 'P' -> READY. i_pipe_halt=1 -> DONE, with o_pipe_valid=0 from the next cycle.
- STEP:
  - Entry and each further 'S' produce exactly one cycle of o_pipe_valid=1, registered the cycle after the byte.
  - 'R' -> RUN. 'P' -> READY. i_pipe_halt -> DONE.
- DONE: o_pipe_valid=0. 'L' -> LOAD. All other bytes are ignored.
- ERROR: o_error=1, o_pipe_reset=1. Only 'L' (-> LOAD, clears o_error) or reset exits.
- Simultaneous events:
  - i_pipe_halt and i_rx_valid in the same cycle in RUN/STEP: halt wins and the byte is dropped.
  - i_rx_valid during the o_imem_wr_en cycle: the byte is accepted as byte 0 of the next word.
- Reset mid-load: the partial word is discarded, with no write. The next load starts at address 0.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined:
  - After the HALT_WORD write, state goes to CHECK.
  - The next byte is compared against the running XOR of all loaded bytes, including the HALT_WORD bytes.
  - Match -> READY. Mismatch -> ERROR.
  - The XOR accumulator clears on LOAD entry.
- Undefined: no CHECK state and no accumulator. HALT_WORD goes directly to READY.

Test Plan:
- Load: bytes 4C 20 01 00 05 FF FF FF FF -> writes addr0=0x20010005 and addr1=0xFFFFFFFF, one strobe each. o_state=2; o_pipe_reset falls the cycle after the second write.
- Run: from READY send 0x52 -> o_pipe_valid=1 continuously. Assert i_pipe_halt 10 cycles later -> o_pipe_valid=0 next cycle, o_state=5. Then send 0x53 -> no valid pulse.
- Step: from READY send 53, 53, 53 spaced 5 cycles apart -> exactly 3 single-cycle o_pipe_valid pulses, each one cycle after its byte. Then send 0x50 -> o_state=2.
- Overflow: 'L' then 32 words of 0x00000000 -> 32 writes to addr 0..31, then o_state=6, o_error=1. A following 'L' clears o_error.
- Reset mid-load: 'L', 12, 34, then i_reset=0 for 2 cycles -> no write, o_state=0. A fresh load of 0x11223344 writes addr0=0x11223344.
- Checksum (macro defined): load 0x20010005 + HALT_WORD, checksum byte 0x24 -> READY. Same load with checksum byte 0x00 -> ERROR, o_error=1.
